// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0-F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Hex nibble to active-low 7-segment pattern.
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display driver with shadowed, tear-free updates.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IW = idx_w(DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [6:0] SEG_INV = {7{~SEG_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = SEG_BLANK ^ SEG_INV;
  localparam logic DP_OFF = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_ACTIVE_LOW}};

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  wrap;
  logic [4*DIGITS-1:0]   val_a;
  logic [4*DIGITS-1:0]   val_s;
  logic [DIGITS-1:0]     dp_a;
  logic [DIGITS-1:0]     dp_s;
  logic [DIGITS-1:0]     dis_a;
  logic [DIGITS-1:0]     dis_s;
  logic [DIGITS-1:0]     lz;
  logic [DIGITS-1:0]     sel;
  logic [3:0]            nib;
  logic [6:0]            dec;
  logic                  blank;
  logic                  dpr;
  logic                  hz;

  assign tick = cnt == CW'(PRESCALE - 1);
  assign wrap = tick && (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        cnt <= '0;
        idx <= wrap ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Enables are kept inverted so the reset frame shows zeros, not blanks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_a   <= '0;
      val_s   <= '0;
      dp_a    <= '0;
      dp_s    <= '0;
      dis_a   <= '0;
      dis_s   <= '0;
      pending <= 1'b0;
    end else begin
      if (wrap && pending) begin
        val_a   <= val_s;
        dp_a    <= dp_s;
        dis_a   <= dis_s;
        pending <= 1'b0;
      end
      if (load) begin
        val_s   <= value;
        dp_s    <= dp;
        dis_s   <= ~digit_en;
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    hz = 1'b1;
    lz = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      hz = hz && (val_a[4*i +: 4] == 4'h0);
      lz[i] = hz;
    end
  end

  always_comb begin
    nib   = '0;
    blank = 1'b0;
    dpr   = 1'b0;
    sel   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = val_a[4*i +: 4];
        blank  = dis_a[i] || (LZ_BLANK && lz[i]);
        dpr    = dp_a[i];
        sel[i] = 1'b1;
      end
    end
  end

  hex7_decode u_dec (
    .nib (nib),
    .seg (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= SEG_OFF;
      seg_dp <= DP_OFF;
      an     <= AN_OFF;
    end else begin
      seg    <= (blank ? SEG_BLANK : dec) ^ SEG_INV;
      seg_dp <= (blank | ~dpr) ^ ~SEG_ACTIVE_LOW;
      an     <= (tick ? '0 : sel) ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: default, LZ-blank and inverted-polarity builds.
module tb_seg_scan_driver;

  typedef struct packed {
    logic [6:0] s0;
    logic       d0;
    logic [6:0] sl;
    logic       dl;
    logic [3:0] an;
    logic       fd;
    logic       pd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = 4'hf;
  logic        load = 1'b0;

  logic [6:0] seg_d, seg_l, seg_p;
  logic       dp_d, dp_l, dp_p;
  logic [3:0] an_d, an_l, an_p;
  logic       fd_d, fd_l, fd_p;
  logic       pd_d, pd_l, pd_p;

  int n_cmp = 0;
  int n_err = 0;

  exp_t q[$];
  exp_t c;

  int          m_cnt, m_idx;
  logic [15:0] m_val, m_vs;
  logic [3:0]  m_dpa, m_dps, m_ena, m_ens;
  logic        m_pend;

  logic [6:0] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp),
    .digit_en(digit_en), .load(load), .seg(seg_d),
    .seg_dp(dp_d), .an(an_d), .frame_done(fd_d), .pending(pd_d)
  );

  seg_scan_driver #(.DIGITS(4), .PRESCALE(4), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst(rst), .value(value), .dp(dp),
    .digit_en(digit_en), .load(load), .seg(seg_l),
    .seg_dp(dp_l), .an(an_l), .frame_done(fd_l), .pending(pd_l)
  );

  seg_scan_driver #(.DIGITS(4), .PRESCALE(4),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_pol (
    .clk(clk), .rst(rst), .value(value), .dp(dp),
    .digit_en(digit_en), .load(load), .seg(seg_p),
    .seg_dp(dp_p), .an(an_p), .frame_done(fd_p), .pending(pd_p)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected registered outputs from pre-edge state
  always @(posedge clk or posedge rst) begin : model
    exp_t e;
    logic tk, wr, bl, lb, np;
    int k;
    if (rst) begin
      q.delete();
      m_cnt <= 0; m_idx <= 0;
      m_val <= '0; m_vs <= '0;
      m_dpa <= '0; m_dps <= '0;
      m_ena <= 4'hf; m_ens <= 4'hf;
      m_pend <= 1'b0;
    end else begin
      k  = m_idx;
      tk = (m_cnt == 3);
      wr = tk && (k == 3);
      bl = !m_ena[k];
      lb = bl || (k != 0 && (m_val >> (4 * k)) == 16'h0);
      e.s0 = bl ? 7'h7f : tbl[m_val[4*k +: 4]];
      e.d0 = bl | ~m_dpa[k];
      e.sl = lb ? 7'h7f : tbl[m_val[4*k +: 4]];
      e.dl = lb | ~m_dpa[k];
      e.an = tk ? 4'hf : ~(4'b0001 << k);
      e.fd = wr;
      np = m_pend;
      if (wr && m_pend) begin
        m_val <= m_vs; m_dpa <= m_dps; m_ena <= m_ens;
        np = 1'b0;
      end
      if (load) begin
        m_vs <= value; m_dps <= dp; m_ens <= digit_en;
        np = 1'b1;
      end
      m_pend <= np;
      e.pd = np;
      m_cnt <= tk ? 0 : m_cnt + 1;
      if (tk) m_idx <= (k == 3) ? 0 : k + 1;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_def", {seg_d, dp_d, an_d, fd_d, pd_d}, {7'h7f, 1'b1, 4'hf, 2'b00});
      check("rst_pol", {seg_p, dp_p, an_p}, 12'h000);
    end else if (q.size() > 0) begin
      c = q.pop_front();
      check("def", {seg_d, dp_d, an_d, fd_d, pd_d},
            {c.s0, c.d0, c.an, c.fd, c.pd});
      check("lz", {seg_l, dp_l, an_l, fd_l, pd_l},
            {c.sl, c.dl, c.an, c.fd, c.pd});
      check("pol", {seg_p, dp_p, an_p, fd_p, pd_p},
            {~c.s0, ~c.d0, ~c.an, c.fd, c.pd});
    end
  end

  task automatic wait_fd();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fd_d) return;
    end
    check("fd_timeout", 0, 1);
  endtask

  // Returns {seg, seg_dp} of instance inst while digit d is selected
  task automatic grab(input int inst, input int d, output logic [7:0] sd);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    sd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst == 0 && an_d == ~oh) begin sd = {seg_d, dp_d}; return; end
      if (inst == 1 && an_l == ~oh) begin sd = {seg_l, dp_l}; return; end
      if (inst == 2 && an_p == oh)  begin sd = {seg_p, dp_p}; return; end
    end
    check("scan_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en,
                         input logic [3:0] p);
    wait_fd();
    @(negedge clk);
    @(negedge clk);
    value = v; digit_en = en; dp = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pend_set", pd_d, 1);
  endtask

  initial begin : stim
    logic [7:0] sd;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("release", {seg_d, dp_d, an_d}, {7'h7f, 1'b1, 4'hf});
    for (int d = 0; d < 4; d++) begin
      grab(0, d, sd);
      check("zero_frame", sd, {7'b0000001, 1'b1});
    end

    do_load(16'h1A7F, 4'hf, 4'h0);
    wait_fd();
    check("pend_clr", pd_d, 0);
    grab(0, 0, sd); check("h1a7f_d0", sd[7:1], 7'b0111000);
    grab(0, 1, sd); check("h1a7f_d1", sd[7:1], 7'b0001111);
    grab(0, 2, sd); check("h1a7f_d2", sd[7:1], 7'b0001000);
    grab(0, 3, sd); check("h1a7f_d3", sd[7:1], 7'b1001111);

    do_load(16'h0050, 4'hf, 4'h0);
    wait_fd();
    grab(1, 0, sd); check("lz50_d0", sd[7:1], 7'b0000001);
    grab(1, 1, sd); check("lz50_d1", sd[7:1], 7'b0100100);
    grab(1, 2, sd); check("lz50_d2", sd[7:1], 7'h7f);
    grab(1, 3, sd); check("lz50_d3", sd[7:1], 7'h7f);

    do_load(16'h0000, 4'hf, 4'h0);
    wait_fd();
    grab(1, 0, sd); check("lz0_d0", sd[7:1], 7'b0000001);
    grab(1, 1, sd); check("lz0_d1", sd[7:1], 7'h7f);
    grab(1, 3, sd); check("lz0_d3", sd[7:1], 7'h7f);

    do_load(16'h3333, 4'hf, 4'h0);
    for (int i = 0; i < 40; i++) begin
      if (m_cnt == 3 && m_idx == 3) break;
      @(negedge clk);
    end
    check("wrap_found", (m_cnt == 3 && m_idx == 3), 1);
    value = 16'h2222; load = 1'b1;
    wait_fd();
    load = 1'b0;
    check("pend_wrap", pd_d, 1);
    grab(0, 0, sd); check("h3333", sd[7:1], 7'b0000110);
    wait_fd();
    check("pend_wrap_clr", pd_d, 0);
    grab(0, 0, sd); check("h2222", sd[7:1], 7'b0010010);

    do_load(16'h1234, 4'b0101, 4'b0011);
    wait_fd();
    grab(0, 0, sd); check("en_d0", sd, {7'b1001100, 1'b0});
    grab(0, 1, sd); check("en_d1", sd, {7'h7f, 1'b1});
    grab(0, 2, sd); check("en_d2", sd, {7'b0010010, 1'b1});
    grab(0, 3, sd); check("en_d3", sd, {7'h7f, 1'b1});

    do_load(16'h8888, 4'hf, 4'h0);
    wait_fd();
    grab(2, 0, sd); check("pol_d0", sd, {7'h7f, 1'b0});
    grab(2, 2, sd); check("pol_d2", sd, {7'h7f, 1'b0});

    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_def", {seg_d, dp_d, an_d, fd_d, pd_d}, {7'h7f, 1'b1, 4'hf, 2'b00});
    check("arst_pol", {seg_p, dp_p, an_p}, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
